// File: rtl/decode_dispatch.sv
// decode_dispatch: registered RV32 decode-and-dispatch stage with per-class issue credits.
// Classes {alu,lsu,muldiv,br}; an instruction is accepted only when its class has a free slot.
// Optional feature macro: DECODE_MULDIV_EN (MULDIV class and its credit counter present).
module decode_dispatch #(
    parameter int unsigned CREDITS_ALU = 4,
    parameter int unsigned CREDITS_LSU = 4,
    parameter int unsigned CREDITS_MD  = 2,
    parameter int unsigned CREDITS_BR  = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        pc_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        out_inst_o,
    output logic [31:0]        out_pc_o,
    output logic [3:0]         out_unit_o,
    output logic               out_is_store_o,
    output logic               out_illegal_o,
    input  logic [3:0]         credit_ret_i,
    output logic [4*CNT_W-1:0] credits_o
);

`ifdef DECODE_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // Sum width leaves headroom for +ret +restore before saturation.
    localparam int unsigned SUM_W = CNT_W + 2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Bit order everywhere: [3]=alu [2]=lsu [1]=muldiv [0]=br.
    logic [3:0]       w_unit;
    logic             w_illegal;
    logic             w_is_store;
    logic [3:0]       w_ret_eff;
    logic [3:0]       w_nonzero;
    logic [3:0]       w_consume;
    logic [3:0]       w_restore;
    logic             w_has_credit;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt [4];

    logic             r_valid;
    logic [31:0]      r_inst;
    logic [31:0]      r_pc;
    logic [3:0]       r_unit;
    logic             r_store;
    logic             r_illegal;

    // Classify the incoming instruction word by opcode (and funct7 for OP).
    always_comb begin
        w_unit     = 4'b0000;
        w_illegal  = 1'b0;
        w_is_store = 1'b0;
        case (inst_i[6:0])
            OPC_OP_IMM, OPC_LUI, OPC_AUIPC: w_unit = 4'b1000;
            OPC_OP: begin
                if (inst_i[31:25] == 7'b0000001) begin
                    if (MD_EN) w_unit = 4'b0010;
                    else       w_illegal = 1'b1;
                end else begin
                    w_unit = 4'b1000;
                end
            end
            OPC_JAL, OPC_JALR, OPC_BRANCH: w_unit = 4'b0001;
            OPC_LOAD: w_unit = 4'b0100;
            OPC_STORE: begin
                w_unit     = 4'b0100;
                w_is_store = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Credit availability with same-cycle return bypass, and the accept handshake.
    always_comb begin
        w_ret_eff = credit_ret_i & {2'b11, MD_EN, 1'b1};
        for (int k = 0; k < 4; k++) w_nonzero[k] = (w_cnt[k] != '0);
        w_has_credit = w_illegal | (|(w_unit & (w_nonzero | w_ret_eff)));
        in_ready_o   = !flush_i & (!r_valid | out_ready_i) & w_has_credit;
        w_accept     = in_valid_i & in_ready_o;
        w_consume    = {4{w_accept}} & w_unit;
        // Illegal entries hold r_unit = 0, so they never restore a credit.
        w_restore    = {4{flush_i & r_valid}} & r_unit;
    end

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        if (k == 1 && !MD_EN) begin : g_off
            logic w_unused_md;
            assign w_unused_md = ^{w_consume[k], w_restore[k]};
            assign w_cnt[k]    = '0;
        end else begin : g_on
            localparam int unsigned CMax = (k == 3) ? CREDITS_ALU :
                                           (k == 2) ? CREDITS_LSU :
                                           (k == 1) ? CREDITS_MD  : CREDITS_BR;
            logic [CNT_W-1:0] r_cnt;
            logic [SUM_W-1:0] w_sum;

            // Next count; consume only happens when cnt != 0 or a return bypasses it.
            always_comb begin
                w_sum = SUM_W'(r_cnt) + SUM_W'(w_ret_eff[k]) + SUM_W'(w_restore[k])
                        - SUM_W'(w_consume[k]);
            end

            // Credit counter, saturating at its class maximum.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= CNT_W'(CMax);
                end else if (w_sum > SUM_W'(CMax)) begin
                    r_cnt <= CNT_W'(CMax);
                end else begin
                    r_cnt <= w_sum[CNT_W-1:0];
                end
            end

            assign w_cnt[k] = r_cnt;
        end
    end

    // Output pipeline register: load on accept, drop on handshake or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_pc      <= '0;
            r_unit    <= '0;
            r_store   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_inst    <= inst_i;
            r_pc      <= pc_i;
            r_unit    <= w_unit;
            r_store   <= w_is_store;
            r_illegal <= w_illegal;
        end else if (flush_i || out_ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid_o    = r_valid;
    assign out_inst_o     = r_inst;
    assign out_pc_o       = r_pc;
    assign out_unit_o     = r_unit;
    assign out_is_store_o = r_store;
    assign out_illegal_o  = r_illegal;
    assign credits_o      = {w_cnt[3], w_cnt[2], w_cnt[1], w_cnt[0]};

endmodule
